// File: rtl/vote_report_uart_tx.sv
// Snapshots four candidate tallies on request and sends them as an 8N1 UART frame:
// header, four counts, XOR checksum.
module vote_report_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cand1_vote,
  input  logic [7:0] cand2_vote,
  input  logic [7:0] cand3_vote,
  input  logic [7:0] cand4_vote,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [2:0]       byte_idx, byte_nx;
  logic [7:0]       c1, c2, c3, c4, chk;
  logic [7:0]       c1_nx, c2_nx, c3_nx, c4_nx, chk_nx;
  logic             tx_nx, busy_nx, done_nx;
  logic             load_c, bit_end_c;
  logic [7:0]       cur_byte_c;

  // Byte currently on the wire, selected from the snapshot.
  always_comb begin
    case (byte_idx)
      3'd0:    cur_byte_c = HEADER;
      3'd1:    cur_byte_c = c1;
      3'd2:    cur_byte_c = c2;
      3'd3:    cur_byte_c = c3;
      3'd4:    cur_byte_c = c4;
      3'd5:    cur_byte_c = chk;
      default: cur_byte_c = HEADER;
    endcase
  end

  assign bit_end_c = (cnt == CNT_MAX);

  // Next-state and registered-output logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = bit_end_c ? '0 : cnt + CNT_W'(1);
    bit_nx   = bit_idx;
    byte_nx  = byte_idx;
    c1_nx    = c1;
    c2_nx    = c2;
    c3_nx    = c3;
    c4_nx    = c4;
    chk_nx   = chk;
    tx_nx    = tx;
    busy_nx  = busy;
    done_nx  = 1'b0;
    load_c   = 1'b0;

    case (state)
      IDLE: begin
        cnt_nx  = '0;
        tx_nx   = 1'b1;
        busy_nx = 1'b0;
        load_c  = start;
      end
      START_BIT: begin
        if (bit_end_c) begin
          state_nx = DATA_BITS;
          bit_nx   = 3'd0;
          tx_nx    = cur_byte_c[0];
        end
      end
      DATA_BITS: begin
        if (bit_end_c) begin
          if (bit_idx == 3'd7) begin
            state_nx = STOP_BIT;
            tx_nx    = 1'b1;
          end else begin
            bit_nx = bit_idx + 3'd1;
            tx_nx  = cur_byte_c[bit_idx + 3'd1];
          end
        end
      end
      STOP_BIT: begin
        if (bit_end_c) begin
          if (byte_idx == LAST_BYTE) begin
            // Frame complete; a start seen on this same edge chains the next frame.
            done_nx  = 1'b1;
            state_nx = IDLE;
            tx_nx    = 1'b1;
            busy_nx  = 1'b0;
            load_c   = start;
          end else begin
            state_nx = START_BIT;
            byte_nx  = byte_idx + 3'd1;
            tx_nx    = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load_c) begin
      state_nx = START_BIT;
      cnt_nx   = '0;
      bit_nx   = 3'd0;
      byte_nx  = 3'd0;
      c1_nx    = cand1_vote;
      c2_nx    = cand2_vote;
      c3_nx    = cand3_vote;
      c4_nx    = cand4_vote;
      chk_nx   = HEADER ^ cand1_vote ^ cand2_vote ^ cand3_vote ^ cand4_vote;
      tx_nx    = 1'b0;
      busy_nx  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      c1       <= '0;
      c2       <= '0;
      c3       <= '0;
      c4       <= '0;
      chk      <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_nx;
      byte_idx <= byte_nx;
      c1       <= c1_nx;
      c2       <= c2_nx;
      c3       <= c3_nx;
      c4       <= c4_nx;
      chk      <= chk_nx;
      tx       <= tx_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

endmodule

// File: tb/tb_vote_report_uart_tx.sv
// Bench for vote_report_uart_tx: a UART decoder pops expected bytes from a scoreboard
// queue, while per-scenario tasks check busy/done timing and line state.
module tb_vote_report_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 60 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cand1_vote = 8'h00;
  logic [7:0] cand2_vote = 8'h00;
  logic [7:0] cand3_vote = 8'h00;
  logic [7:0] cand4_vote = 8'h00;
  logic       tx, busy, done;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  vote_report_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cand1_vote(cand1_vote), .cand2_vote(cand2_vote),
    .cand3_vote(cand3_vote), .cand4_vote(cand4_vote),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xsum(input logic [7:0] a, b, c, d);
    return 8'hA5 ^ a ^ b ^ c ^ d;
  endfunction

  task automatic push_frame(input logic [7:0] a, b, c, d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
    exp_q.push_back(xsum(a, b, c, d));
  endtask

  // Decodes tx by sampling at the middle of every bit period on falling clock edges.
  task automatic uart_monitor();
    int         ph;
    bit         act;
    logic [7:0] sh;
    logic [7:0] want;
    act = 1'b0;
    ph  = 0;
    sh  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        act = 1'b0;
        continue;
      end
      if (!act) begin
        if (tx === 1'b0) begin
          act = 1'b1;
          ph  = 0;
        end
      end else begin
        ph++;
      end
      if (act) begin
        if (ph == CPB / 2) begin
          vectors++;
          if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL start_bit: tx=%b expected 0 at %0t", tx, $time);
          end
        end
        for (int k = 0; k < 8; k++)
          if (ph == CPB * (k + 1) + CPB / 2) sh[k] = tx;
        if (ph == CPB * 9 + CPB / 2) begin
          act = 1'b0;
          vectors++;
          if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_bit: tx=%b expected 1 at %0t", tx, $time);
          end
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_byte: got %02h expected none at %0t", sh, $time);
          end else begin
            want = exp_q.pop_front();
            if (sh !== want) begin
              miscompares++;
              $display("FAIL byte: got %02h expected %02h at %0t", sh, want, $time);
            end
          end
        end
      end
    end
  endtask

  task automatic check_queue_empty(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_leftover: %0d bytes undelivered, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Drives one start pulse with the given tallies and checks the immediate response.
  task automatic pulse_start(input logic [7:0] a, b, c, d);
    @(negedge clock);
    cand1_vote = a;
    cand2_vote = b;
    cand3_vote = c;
    cand4_vote = d;
    start      = 1'b1;
    push_frame(a, b, c, d);
    @(posedge clock);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_busy: busy=%b expected 1", busy);
    end
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_tx: tx=%b expected 0", tx);
    end
  endtask

  // Watches one frame; optionally changes tallies or re-pulses start at given cycles.
  task automatic watch_frame(input int tally_at, input int start_a, input int start_b,
                             output int busy_cycles, output int dones, output int done_at);
    int cyc;
    busy_cycles = 0;
    dones       = 0;
    done_at     = -1;
    for (int i = 0; i < FRAME + 20; i++) begin
      @(negedge clock);
      cyc   = i + 1;
      start = (cyc == start_a) || (cyc == start_b);
      if (cyc == tally_at) begin
        cand1_vote = 8'h77;
        cand2_vote = 8'h77;
        cand3_vote = 8'h77;
        cand4_vote = 8'h77;
      end
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        dones++;
        done_at = i;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_frame_stats(input string name, input int bc, input int dn, input int da);
    vectors++;
    if (bc != FRAME) begin
      miscompares++;
      $display("FAIL %s_busy_len: %0d cycles, expected %0d", name, bc, FRAME);
    end
    vectors++;
    if (dn != 1) begin
      miscompares++;
      $display("FAIL %s_done_count: %0d pulses, expected 1", name, dn);
    end
    vectors++;
    if (da != FRAME) begin
      miscompares++;
      $display("FAIL %s_done_time: cycle %0d, expected %0d", name, da, FRAME);
    end
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle_after: tx=%b busy=%b expected tx=1 busy=0", name, tx, busy);
    end
    check_queue_empty(name);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b expected 1/0/0", tx, busy, done);
    end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      vectors++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_cycle%0d: tx=%b busy=%b done=%b expected 1/0/0", i, tx, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    int bc, dn, da;
    pulse_start(8'h03, 8'h00, 8'h10, 8'hFF);
    watch_frame(0, 0, 0, bc, dn, da);
    check_frame_stats("basic", bc, dn, da);
  endtask

  task automatic test_snapshot();
    int bc, dn, da;
    pulse_start(8'h03, 8'h00, 8'h10, 8'hFF);
    watch_frame(5, 0, 0, bc, dn, da);
    check_frame_stats("snapshot", bc, dn, da);
  endtask

  task automatic test_start_ignored();
    int bc, dn, da;
    pulse_start(8'h12, 8'h34, 8'h56, 8'h78);
    watch_frame(0, 10, 100, bc, dn, da);
    check_frame_stats("ignored", bc, dn, da);
  endtask

  task automatic test_reset_mid();
    int bad;
    pulse_start(8'h01, 8'h02, 8'h03, 8'h04);
    repeat (121) @(negedge clock);
    vectors++;
    if (exp_q.size() != 3) begin
      miscompares++;
      $display("FAIL midreset_progress: %0d bytes pending, expected 3", exp_q.size());
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_async: tx=%b busy=%b done=%b expected 1/0/0", tx, busy, done);
    end
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midreset_resume: %0d active cycles after release, expected 0", bad);
    end
    check_queue_empty("midreset");
  endtask

  task automatic test_back_to_back();
    int bh, dn, bad_done;
    @(negedge clock);
    cand1_vote = 8'hAA;
    cand2_vote = 8'h55;
    cand3_vote = 8'h00;
    cand4_vote = 8'hFF;
    start      = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(8'hAA, 8'h55, 8'h00, 8'hFF);
    @(posedge clock);
    #1;
    vectors++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b tx=%b expected 1/0", busy, tx);
    end
    bh = 0;
    dn = 0;
    bad_done = 0;
    for (int i = 0; i < 3 * FRAME + 10; i++) begin
      @(negedge clock);
      if (i + 1 == 2 * FRAME + FRAME / 2) start = 1'b0;
      if (i < 3 * FRAME && busy === 1'b1) bh++;
      if (done === 1'b1) begin
        dn++;
        if (i % FRAME != 0) bad_done++;
      end
    end
    start = 1'b0;
    vectors++;
    if (bh != 3 * FRAME) begin
      miscompares++;
      $display("FAIL b2b_busy: %0d busy cycles, expected %0d", bh, 3 * FRAME);
    end
    vectors++;
    if (dn != 3) begin
      miscompares++;
      $display("FAIL b2b_done_count: %0d pulses, expected 3", dn);
    end
    vectors++;
    if (bad_done != 0) begin
      miscompares++;
      $display("FAIL b2b_done_spacing: %0d misplaced pulses, expected 0", bad_done);
    end
    vectors++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_final_idle: busy=%b tx=%b expected 0/1", busy, tx);
    end
    check_queue_empty("b2b");
  endtask

  initial begin
    fork
      uart_monitor();
    join_none
    test_reset();
    test_basic();
    test_snapshot();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
